morse_char_ctrl: RTL and testbench
==================================

Name: morse_char_ctrl

Overview:
Controller downstream of the Morse key decoder (`morseio`). It gates the decoder through its reset and translates each completed symbol (length plus dot/dash bits) into ASCII. It inserts a space after a word gap on the raw key line and buffers characters in a small FIFO with a valid/ready output handshake. It is the only path from the key decoder to the character consumer (UART/display).

Parameters:
FRQ, 10, clock cycles per millisecond (same scaling as the decoder).
NWORD_MS, 1400, key-low time in ms, counted from the last accepted symbol, that produces a word space.
DEPTH, 8, FIFO depth in characters; power of 2, minimum 2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  1 = decoding active; 0 = decoder held in reset, symbols ignored
key_in  in  1  raw key level (same signal the decoder receives), used only for word-gap timing
sym_valid  in  1  one-cycle pulse from the decoder: symbol complete
sym_len  in  4  number of elements in the symbol
sym_bits  in  8  elements, LSB = last element, bit[len-1] = first element; 0 = dot, 1 = dash
dec_rst  out  1  reset to the decoder
char_valid  out  1  FIFO non-empty
char_data  out  8  ASCII at the FIFO head
char_ready  in  1  consumer accepts char_data when char_valid && char_ready
overflow  out  1  sticky: a character was dropped because the FIFO was full
err_cnt  out  8  count of undecodable symbols, saturates at 255

Behaviour:
- Reset values:
  - dec_rst = 1, char_valid = 0, char_data = 0x00, overflow = 0, err_cnt = 0.
  - FIFO empty, gap FSM in IDLE, gap counter 0.
- dec_rst is registered: dec_rst <= rst | ~enable (1-cycle latency).
- sym_valid is ignored while enable = 0 or dec_rst = 1.
- Lookup stage:
  - A sym_valid sampled in cycle N is registered with its translated code.
  - The code is written to the FIFO at the end of cycle N+1.
  - If the FIFO was empty, char_valid = 1 in cycle N+2.
  - The stage never stalls; it accepts sym_valid every cycle.
- Translation table:
  - Covers A-Z (lengths 1-4) and 0-9 (length 5) per ITU Morse.
  - Bits above sym_len are ignored.
  - sym_len = 0, sym_len > 5, or an unlisted pattern maps to '?' (0x3F) and increments err_cnt, saturating at 255.
- Gap FSM (word spaces):
  - IDLE: no character pushed since the last space; the counter holds 0.
  - IDLE -> ARMED on any symbol push, including '?'.
  - ARMED:
    - The counter increments each cycle while key_in = 0 and resets to 0 while key_in = 1.
    - A symbol push also resets the counter and the FSM stays in ARMED.
    - When the counter reaches NWORD_MS*FRQ-1, go to PEND.
  - PEND:
    - Push 0x20 in the first cycle with no symbol push; a symbol push has priority and the space waits one cycle.
    - After the space push, go to IDLE.
    - A space is never inserted twice in a row and never before the first character.
  - enable = 0 forces IDLE and clears the counter.
- FIFO:
  - Push and pop in the same cycle are both performed, including when full; no overflow in that case.
  - Push when full without a pop: the character is dropped and overflow is set.
  - overflow clears only on rst.
  - char_data is stable while char_valid = 1 and char_ready = 0.
  - Read and write pointers wrap modulo DEPTH; an extra pointer bit distinguishes full from empty.
- enable = 0 does not flush the FIFO; queued characters still drain.
- Reset mid-operation: all state returns to reset values in the next cycle, including pending space and in-flight lookup.

Decomposition:
- Package morse_pkg:
  - ASCII constants (CH_SPACE = 0x20, CH_ERR = 0x3F).
  - Gap FSM state typedef (IDLE, ARMED, PEND).
  - Function morse_lookup(len, bits) -> {hit, ascii}, shared with any future encoder/keyer.
- Sub-module morse_char_fifo: parameter DEPTH, width 8; push/pop/full/empty/head.
- The top level holds the lookup register, gap FSM, counters and dec_rst.

Test Plan:
1. Symbol translation: sym_valid with len 2, bits 0x01 at cycle N, char_ready = 1 -> char_valid = 1, char_data = 0x41 ('A') at cycle N+2. Then len 5, bits 0x1F -> 0x30 ('0').
2. Word gap: FRQ = 2, NWORD_MS = 5.
   - 'E' (len 1, bits 0), then key_in low for 10 cycles -> 0x45 followed by exactly one 0x20.
   - Key low for 50 more cycles -> no further 0x20.
   - Key high for 3 cycles before the threshold -> counter restarts, no space.
3. Errors: len 0, then len 7, then len 4 with bits 0x0F -> three 0x3F outputs, err_cnt = 3. Forcing 260 errors -> err_cnt = 255.
4. FIFO overflow (DEPTH = 8, char_ready = 0): 9 symbols 'T' -> 8 stored, overflow = 1. Then char_ready = 1 -> exactly 8 × 0x54 drained, overflow stays 1.
5. Back-pressure and simultaneity:
   - Full FIFO with push and pop in the same cycle -> count unchanged, overflow = 0.
   - Space PEND coinciding with a symbol push -> symbol is written first, 0x20 one cycle later.
6. Enable and reset: enable = 0 -> dec_rst = 1 next cycle, sym_valid ignored, queued characters still drain. rst asserted mid-gap with 3 queued characters -> next cycle char_valid = 0, overflow = 0, err_cnt = 0, dec_rst = 1.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions: ASCII constants, word-gap FSM encoding and the
// symbol-to-ASCII lookup used by the character controller.
package morse_pkg;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_ERR   = 8'h3F;

  typedef logic [1:0] gap_state_t;
  localparam gap_state_t GAP_IDLE  = 2'd0;
  localparam gap_state_t GAP_ARMED = 2'd1;
  localparam gap_state_t GAP_PEND  = 2'd2;

  // Returns {hit, ascii}; bit[len-1] of bits is the first element, 1 = dash.
  function automatic logic [8:0] morse_lookup(input logic [3:0] len, input logic [7:0] bits);
    logic [7:0] mask;
    logic [7:0] m;
    logic [7:0] a;
    mask = (8'd1 << len) - 8'd1;
    m    = bits & mask;
    a    = CH_ERR;
    if (len != 4'd0 && len <= 4'd5) begin
      case ({len[2:0], m[4:0]})
        {3'd1, 5'b00000}: a = "E";
        {3'd1, 5'b00001}: a = "T";
        {3'd2, 5'b00000}: a = "I";
        {3'd2, 5'b00001}: a = "A";
        {3'd2, 5'b00010}: a = "N";
        {3'd2, 5'b00011}: a = "M";
        {3'd3, 5'b00000}: a = "S";
        {3'd3, 5'b00001}: a = "U";
        {3'd3, 5'b00010}: a = "R";
        {3'd3, 5'b00011}: a = "W";
        {3'd3, 5'b00100}: a = "D";
        {3'd3, 5'b00101}: a = "K";
        {3'd3, 5'b00110}: a = "G";
        {3'd3, 5'b00111}: a = "O";
        {3'd4, 5'b00000}: a = "H";
        {3'd4, 5'b00001}: a = "V";
        {3'd4, 5'b00010}: a = "F";
        {3'd4, 5'b00100}: a = "L";
        {3'd4, 5'b00110}: a = "P";
        {3'd4, 5'b00111}: a = "J";
        {3'd4, 5'b01000}: a = "B";
        {3'd4, 5'b01001}: a = "X";
        {3'd4, 5'b01010}: a = "C";
        {3'd4, 5'b01011}: a = "Y";
        {3'd4, 5'b01100}: a = "Z";
        {3'd4, 5'b01101}: a = "Q";
        {3'd5, 5'b11111}: a = "0";
        {3'd5, 5'b01111}: a = "1";
        {3'd5, 5'b00111}: a = "2";
        {3'd5, 5'b00011}: a = "3";
        {3'd5, 5'b00001}: a = "4";
        {3'd5, 5'b00000}: a = "5";
        {3'd5, 5'b10000}: a = "6";
        {3'd5, 5'b11000}: a = "7";
        {3'd5, 5'b11100}: a = "8";
        {3'd5, 5'b11110}: a = "9";
        default:          a = CH_ERR;
      endcase
    end
    return {a != CH_ERR, a};
  endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// Character FIFO with an extra pointer bit for full/empty; a push into a full
// FIFO is accepted only when a pop frees the slot in the same cycle.
module morse_char_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign head    = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + (AW+1)'(1);
      end
      if (do_pop) rp <= rp + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/morse_char_ctrl.sv
// Turns decoder symbols into ASCII, inserts word spaces after a long key-low
// gap and queues characters for a valid/ready consumer.
module morse_char_ctrl
  import morse_pkg::*;
#(
  parameter int FRQ      = 10,
  parameter int NWORD_MS = 1400,
  parameter int DEPTH    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       key_in,
  input  logic       sym_valid,
  input  logic [3:0] sym_len,
  input  logic [7:0] sym_bits,
  output logic       dec_rst,
  output logic       char_valid,
  output logic [7:0] char_data,
  input  logic       char_ready,
  output logic       overflow,
  output logic [7:0] err_cnt
);
  localparam int THR = NWORD_MS * FRQ;
  localparam int CW  = $clog2(THR + 1);

  logic          accept, lk_vld, space_push, push, full, empty, drop;
  logic [7:0]    lk_code, push_data;
  logic [8:0]    lk_res;
  logic [CW-1:0] cnt;
  gap_state_t    state;

  assign accept     = sym_valid & enable & ~dec_rst;
  assign lk_res     = morse_lookup(sym_len, sym_bits);
  // A symbol leaving the lookup stage always wins; the space waits a cycle.
  assign space_push = enable & (state == GAP_PEND) & ~lk_vld;
  assign push       = lk_vld | space_push;
  assign push_data  = lk_vld ? lk_code : CH_SPACE;
  assign char_valid = ~empty;

  morse_char_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_data),
    .pop   (char_ready),
    .full  (full),
    .empty (empty),
    .head  (char_data),
    .drop  (drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_rst  <= 1'b1;
      lk_vld   <= 1'b0;
      lk_code  <= '0;
      err_cnt  <= '0;
      overflow <= 1'b0;
      state    <= GAP_IDLE;
      cnt      <= '0;
    end else begin
      dec_rst <= ~enable;
      lk_vld  <= accept;
      if (accept) lk_code <= lk_res[7:0];
      if (accept && !lk_res[8] && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (drop) overflow <= 1'b1;

      if (!enable) begin
        state <= GAP_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          GAP_IDLE: begin
            cnt <= '0;
            if (lk_vld) state <= GAP_ARMED;
          end
          GAP_ARMED: begin
            if (lk_vld || key_in) cnt <= '0;
            else if (cnt == CW'(THR - 1)) begin
              state <= GAP_PEND;
              cnt   <= '0;
            end else cnt <= cnt + CW'(1);
          end
          GAP_PEND: begin
            cnt <= '0;
            if (!lk_vld) state <= GAP_IDLE;
          end
          default: begin
            state <= GAP_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_char_ctrl.sv
// Directed bench for morse_char_ctrl with a short word gap (FRQ=2, NWORD_MS=5).
module tb_morse_char_ctrl;
  logic       clk = 1'b0;
  logic       rst, enable, key_in, sym_valid, char_ready;
  logic [3:0] sym_len;
  logic [7:0] sym_bits;
  logic       dec_rst, char_valid, overflow;
  logic [7:0] char_data, err_cnt;

  int errors = 0;
  int checks = 0;
  logic [7:0] cap [$];

  morse_char_ctrl #(.FRQ(2), .NWORD_MS(5), .DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .key_in     (key_in),
    .sym_valid  (sym_valid),
    .sym_len    (sym_len),
    .sym_bits   (sym_bits),
    .dec_rst    (dec_rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .overflow   (overflow),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Record every character the consumer accepts.
  always @(posedge clk)
    if (!rst && char_valid && char_ready) cap.push_back(char_data);

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] len, input logic [7:0] bits);
    sym_valid = 1'b1; sym_len = len; sym_bits = bits;
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; sym_valid = 1'b0; key_in = 1'b1; char_ready = 1'b1;
    tick(2);
    rst = 1'b0; enable = 1'b1;
    tick();
    cap.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; sym_valid = 1'b0; sym_len = '0; sym_bits = '0;
    key_in = 1'b1; char_ready = 1'b0;
    tick(2);
    checks++; if (dec_rst !== 1'b1)     begin errors++; $display("FAIL reset_dec_rst: got %b exp 1", dec_rst); end
    checks++; if (char_valid !== 1'b0)  begin errors++; $display("FAIL reset_char_valid: got %b exp 0", char_valid); end
    checks++; if (char_data !== 8'h00)  begin errors++; $display("FAIL reset_char_data: got %h exp 00", char_data); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
    checks++; if (err_cnt !== 8'h00)    begin errors++; $display("FAIL reset_err_cnt: got %h exp 00", err_cnt); end
  endtask

  task automatic test_translate();
    do_reset();
    checks++; if (dec_rst !== 1'b0) begin errors++; $display("FAIL xl_dec_rst_release: got %b exp 0", dec_rst); end
    send(4'd2, 8'h01);
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL xl_latency_n1: got %b exp 0", char_valid); end
    tick();
    checks++; if (char_valid !== 1'b1 || char_data !== 8'h41)
      begin errors++; $display("FAIL xl_A: got v=%b d=%h exp v=1 d=41", char_valid, char_data); end
    send(4'd5, 8'h1F);
    tick();
    checks++; if (char_valid !== 1'b1 || char_data !== 8'h30)
      begin errors++; $display("FAIL xl_0: got v=%b d=%h exp v=1 d=30", char_valid, char_data); end
    send(4'd4, 8'hF4); // upper bits ignored: .-.. = 'L'
    tick();
    checks++; if (char_data !== 8'h4C) begin errors++; $display("FAIL xl_L_masked: got %h exp 4c", char_data); end
  endtask

  task automatic test_word_gap();
    do_reset();
    send(4'd1, 8'h00);
    key_in = 1'b0;
    tick(15);
    checks++; if (cap.size() != 2 || cap[0] !== 8'h45 || cap[1] !== 8'h20)
      begin errors++; $display("FAIL gap_space: got n=%0d exp n=2 (45,20)", cap.size()); end
    tick(50);
    checks++; if (cap.size() != 2) begin errors++; $display("FAIL gap_no_repeat: got n=%0d exp 2", cap.size()); end

    do_reset();
    send(4'd1, 8'h00);
    key_in = 1'b0; tick(6);
    key_in = 1'b1; tick(3);
    key_in = 1'b0; tick(6);
    checks++; if (cap.size() != 1) begin errors++; $display("FAIL gap_restart: got n=%0d exp 1", cap.size()); end
    tick(12);
    checks++; if (cap.size() != 2 || cap[1] !== 8'h20)
      begin errors++; $display("FAIL gap_after_restart: got n=%0d exp 2 with 20", cap.size()); end
  endtask

  task automatic test_errors();
    do_reset();
    send(4'd0, 8'h00);
    send(4'd7, 8'h00);
    send(4'd4, 8'h0F);
    tick(4);
    checks++; if (cap.size() != 3 || cap[0] !== 8'h3F || cap[1] !== 8'h3F || cap[2] !== 8'h3F)
      begin errors++; $display("FAIL err_chars: got n=%0d exp three 3f", cap.size()); end
    checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL err_cnt3: got %0d exp 3", err_cnt); end
    sym_valid = 1'b1; sym_len = 4'd0; sym_bits = 8'h00;
    tick(257);
    sym_valid = 1'b0;
    tick(3);
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_cnt_sat: got %0d exp 255", err_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL err_no_ovf: got %b exp 0", overflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    char_ready = 1'b0;
    sym_valid = 1'b1; sym_len = 4'd1; sym_bits = 8'h01;
    tick(9);
    sym_valid = 1'b0;
    tick(2);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", overflow); end
    checks++; if (char_valid !== 1'b1 || char_data !== 8'h54)
      begin errors++; $display("FAIL ovf_head: got v=%b d=%h exp v=1 d=54", char_valid, char_data); end
    char_ready = 1'b1;
    tick(12);
    checks++; if (cap.size() != 8) begin errors++; $display("FAIL ovf_drain_count: got %0d exp 8", cap.size()); end
    foreach (cap[i]) begin
      checks++; if (cap[i] !== 8'h54) begin errors++; $display("FAIL ovf_drain_data[%0d]: got %h exp 54", i, cap[i]); end
    end
    checks++; if (overflow !== 1'b1 || char_valid !== 1'b0)
      begin errors++; $display("FAIL ovf_sticky: got ovf=%b v=%b exp ovf=1 v=0", overflow, char_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    char_ready = 1'b0;
    sym_valid = 1'b1; sym_len = 4'd1; sym_bits = 8'h01;
    tick(8);
    sym_valid = 1'b0;
    tick();
    send(4'd1, 8'h00);   // 'E' arrives at the FIFO while it is full
    char_ready = 1'b1;   // pop in the same cycle as that push
    tick();
    char_ready = 1'b0;
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_no_ovf: got %b exp 0", overflow); end
    cap.delete();
    char_ready = 1'b1;
    tick(12);
    checks++; if (cap.size() != 8 || cap[7] !== 8'h45)
      begin errors++; $display("FAIL simul_count: got n=%0d exp 8 ending in 45", cap.size()); end

    // Symbol leaves the lookup stage exactly when the FSM enters PEND.
    do_reset();
    send(4'd1, 8'h00);
    key_in = 1'b0;
    tick(10);
    send(4'd1, 8'h01);
    tick(20);
    checks++; if (cap.size() != 3 || cap[0] !== 8'h45 || cap[1] !== 8'h54 || cap[2] !== 8'h20)
      begin errors++; $display("FAIL pend_priority: got n=%0d exp 3 (45,54,20)", cap.size()); end
  endtask

  task automatic test_enable_reset();
    do_reset();
    char_ready = 1'b0;
    send(4'd1, 8'h01);
    send(4'd1, 8'h01);
    tick(2);
    enable = 1'b0;
    tick();
    checks++; if (dec_rst !== 1'b1) begin errors++; $display("FAIL en_dec_rst: got %b exp 1", dec_rst); end
    send(4'd1, 8'h00);
    tick(2);
    char_ready = 1'b1;
    tick(5);
    checks++; if (cap.size() != 2 || cap[1] !== 8'h54)
      begin errors++; $display("FAIL en_drain: got n=%0d exp 2 (54,54)", cap.size()); end

    do_reset();
    char_ready = 1'b0;
    send(4'd0, 8'h00);
    send(4'd1, 8'h00);
    send(4'd1, 8'h01);
    key_in = 1'b0;
    tick(4);
    checks++; if (char_valid !== 1'b1 || err_cnt !== 8'd1)
      begin errors++; $display("FAIL rst_pre: got v=%b err=%0d exp v=1 err=1", char_valid, err_cnt); end
    rst = 1'b1;
    tick();
    checks++; if (char_valid !== 1'b0 || overflow !== 1'b0 || err_cnt !== 8'd0 || dec_rst !== 1'b1 || char_data !== 8'h00)
      begin errors++; $display("FAIL rst_mid: got v=%b ovf=%b err=%0d dr=%b d=%h exp 0 0 0 1 00",
                               char_valid, overflow, err_cnt, dec_rst, char_data); end
    rst = 1'b0; char_ready = 1'b1;
    tick(20);
    checks++; if (cap.size() != 0) begin errors++; $display("FAIL rst_no_space: got n=%0d exp 0", cap.size()); end
  endtask

  initial begin
    test_reset();
    test_translate();
    test_word_gap();
    test_errors();
    test_overflow();
    test_back_to_back();
    test_enable_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
